syscall_controller: RTL and testbench

//  Sequences MIPS SYSCALL execution. Sits beside the execute stage and is triggered by the

---
 rtl/mips_syscall_pkg.sv | 43 ++++
 rtl/syscall_controller.sv | 176 +++++++++++++++++
 tb/tb_syscall_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_syscall_pkg.sv
// Shared definitions for the MIPS SYSCALL sequencer.
// Holds the service codes carried in $v0, the output type codes and the
// controller state encoding. The display sink and the bench use it as well.
package mips_syscall_pkg;

   // Service codes compared against the full width of $v0
   localparam int unsigned SVC_PRINT_INT  = 32'd1;
   localparam int unsigned SVC_EXIT       = 32'd10;
   localparam int unsigned SVC_PRINT_CHAR = 32'd11;

   // Output payload type codes
   localparam logic [1:0] OUT_TYPE_NONE = 2'b00;
   localparam logic [1:0] OUT_TYPE_INT  = 2'b01;
   localparam logic [1:0] OUT_TYPE_CHAR = 2'b10;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ISSUE  = 2'b01,
      ST_DONE   = 2'b10,
      ST_HALTED = 2'b11
   } sc_state_e;

   // Decoded service class
   typedef enum logic [1:0] {
      SVC_K_NOP  = 2'b00,
      SVC_K_INT  = 2'b01,
      SVC_K_CHAR = 2'b10,
      SVC_K_EXIT = 2'b11
   } svc_kind_e;

   // Output type code that goes with a print service class
   function automatic logic [1:0] out_type_of(input svc_kind_e kind);
      logic [1:0] t;
      case (kind)
         SVC_K_INT:  t = OUT_TYPE_INT;
         SVC_K_CHAR: t = OUT_TYPE_CHAR;
         default:    t = OUT_TYPE_NONE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/syscall_controller.sv
// SYSCALL sequencer sitting beside the execute stage.
// When a valid SYSCALL reaches execute it decodes the service in v0, stalls the
// pipeline, offers print payloads to the output sink over valid/ready, latches a
// sticky halt on the exit service and counts every retired syscall.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   valid, is_syscall execute-stage instruction valid / funct decoder SYSCALL flag
//   v0, a0            forwarded service code and argument
//   out_ready         sink accepts the payload this cycle
//   stall             freeze PC and IF/ID/EX registers
//   out_valid         out_data / out_type are valid
//   out_data          print payload, held stable while out_valid is high
//   out_type          00 none, 01 integer, 10 char
//   halt              sticky, CPU stopped by the exit service
//   syscall_count     retired syscalls, wraps modulo 2^CNT_W
module syscall_controller
   import mips_syscall_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic              is_syscall,
   input  logic [DATA_W-1:0] v0,
   input  logic [DATA_W-1:0] a0,
   input  logic              out_ready,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_type,
   output logic              halt,
   output logic [CNT_W-1:0]  syscall_count
);

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   sc_state_e         state_r;
   sc_state_e         state_nxt_s;
   svc_kind_e         svc_s;
   logic              trigger_s;
   logic              stall_s;
   logic              load_out_s;
   logic              count_inc_s;
   logic [DATA_W-1:0] out_data_r;
   logic [DATA_W-1:0] out_data_nxt_s;
   logic [1:0]        out_type_r;
   logic [CNT_W-1:0]  count_r;

   // Gating with rst_n keeps the combinational stall low while reset is held,
   // even if the pipeline still presents the syscall.
   assign trigger_s = rst_n & valid & is_syscall;

   // Service decode over the full width of v0
   always_comb begin
      svc_s = SVC_K_NOP;
      if (v0 == DATA_W'(SVC_PRINT_INT)) begin
         svc_s = SVC_K_INT;
      end else if (v0 == DATA_W'(SVC_PRINT_CHAR)) begin
         svc_s = SVC_K_CHAR;
      end else if (v0 == DATA_W'(SVC_EXIT)) begin
         svc_s = SVC_K_EXIT;
      end else begin
         svc_s = SVC_K_NOP;
      end
   end

   // Payload selection: char prints carry only the low byte of a0
   always_comb begin
      out_data_nxt_s = a0;
      if (svc_s == SVC_K_CHAR) begin
         out_data_nxt_s = DATA_W'(a0[7:0]);
      end else begin
         out_data_nxt_s = a0;
      end
   end

   // Next-state, stall and counter-increment decode
   always_comb begin
      state_nxt_s = state_r;
      stall_s     = 1'b0;
      load_out_s  = 1'b0;
      count_inc_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (trigger_s) begin
               case (svc_s)
                  SVC_K_INT, SVC_K_CHAR: begin
                     state_nxt_s = ST_ISSUE;
                     stall_s     = 1'b1;
                     load_out_s  = 1'b1;
                  end
                  SVC_K_EXIT: begin
                     state_nxt_s = ST_HALTED;
                     stall_s     = 1'b1;
                     count_inc_s = 1'b1;
                  end
                  default: begin
                     // Unknown service retires immediately without stalling
                     state_nxt_s = ST_IDLE;
                     count_inc_s = 1'b1;
                  end
               endcase
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            stall_s = 1'b1;
            if (out_ready) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_DONE: begin
            // The held syscall retires on this edge; a trigger seen here is that
            // same instruction and must not start a second service.
            count_inc_s = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         ST_HALTED: begin
            stall_s     = 1'b1;
            state_nxt_s = ST_HALTED;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Print payload register, loaded only when a print is accepted in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r <= DATA_ZERO;
         out_type_r <= OUT_TYPE_NONE;
      end else if (load_out_s) begin
         out_data_r <= out_data_nxt_s;
         out_type_r <= out_type_of(svc_s);
      end else begin
         out_data_r <= out_data_r;
         out_type_r <= out_type_r;
      end
   end

   // Retired-syscall counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= CNT_ZERO;
      end else if (count_inc_s) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign stall         = stall_s;
   assign out_valid     = (state_r == ST_ISSUE);
   assign halt          = (state_r == ST_HALTED);
   assign out_data      = out_data_r;
   assign out_type      = out_type_r;
   assign syscall_count = count_r;

endmodule

// File: tb/tb_syscall_controller.sv
// Self-checking bench for syscall_controller: a directed vector table, hand
// sequences for halt/reset/wrap corners and a randomized run checked against
// a behavioural model of the syscall rules.
module tb_syscall_controller;
   import mips_syscall_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, valid, is_syscall, out_ready;
   logic [31:0] v0, a0;
   logic        stall, out_valid, halt;
   logic [31:0] out_data;
   logic [1:0]  out_type;
   logic [15:0] syscall_count;
   logic        stall4, out_valid4, halt4;
   logic [31:0] out_data4;
   logic [1:0]  out_type4;
   logic [3:0]  syscall_count4;

   syscall_controller #(.DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .is_syscall(is_syscall),
      .v0(v0), .a0(a0), .out_ready(out_ready), .stall(stall),
      .out_valid(out_valid), .out_data(out_data), .out_type(out_type),
      .halt(halt), .syscall_count(syscall_count));

   syscall_controller #(.DATA_W(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .valid(valid), .is_syscall(is_syscall),
      .v0(v0), .a0(a0), .out_ready(out_ready), .stall(stall4),
      .out_valid(out_valid4), .out_data(out_data4), .out_type(out_type4),
      .halt(halt4), .syscall_count(syscall_count4));

   int checks = 0;
   int errors = 0;

   // Behavioural model: what the syscall unit is doing right now
   bit          m_halted;
   bit          m_offering;   // print payload on offer to the sink
   bit          m_retiring;   // print accepted, instruction retires this cycle
   logic [31:0] m_data;
   logic [1:0]  m_type;
   int unsigned m_count;

   typedef struct {
      bit          vld, iss, rdy;
      logic [31:0] v0, a0;
      bit          e_stall, e_ov;
      logic [31:0] e_data;
      logic [1:0]  e_type;
      int unsigned e_cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void m_reset();
      m_halted = 1'b0; m_offering = 1'b0; m_retiring = 1'b0;
      m_data = 32'd0; m_type = 2'd0; m_count = 0;
   endfunction

   function automatic bit is_print(input logic [31:0] code);
      return (code == 32'd1) || (code == 32'd11);
   endfunction

   // Model update at a rising edge, using the inputs presented during the cycle
   function automatic void m_edge();
      if (m_halted) begin
         m_halted = 1'b1;
      end else if (m_offering) begin
         if (out_ready) begin
            m_offering = 1'b0;
            m_retiring = 1'b1;
         end
      end else if (m_retiring) begin
         m_retiring = 1'b0;
         m_count++;
      end else if (valid && is_syscall) begin
         if (is_print(v0)) begin
            m_offering = 1'b1;
            m_data = (v0 == 32'd11) ? {24'd0, a0[7:0]} : a0;
            m_type = (v0 == 32'd11) ? 2'b10 : 2'b01;
         end else begin
            if (v0 == 32'd10) m_halted = 1'b1;
            m_count++;
         end
      end
   endfunction

   task automatic check_model(input string tag);
      bit es, ev;
      es = m_halted || m_offering ||
           (!m_retiring && valid && is_syscall && (is_print(v0) || v0 == 32'd10));
      ev = !m_halted && m_offering;
      chk($sformatf("%s stall", tag), {31'd0, stall}, {31'd0, es});
      chk($sformatf("%s out_valid", tag), {31'd0, out_valid}, {31'd0, ev});
      chk($sformatf("%s halt", tag), {31'd0, halt}, {31'd0, m_halted});
      chk($sformatf("%s count", tag), {16'd0, syscall_count}, m_count & 32'h0000FFFF);
      chk($sformatf("%s count4", tag), {28'd0, syscall_count4}, m_count & 32'h0000000F);
      chk($sformatf("%s stall4", tag), {31'd0, stall4}, {31'd0, es});
      if (ev) begin
         chk($sformatf("%s out_data", tag), out_data, m_data);
         chk($sformatf("%s out_type", tag), {30'd0, out_type}, {30'd0, m_type});
      end
   endtask

   // One clock cycle: check mid-cycle, then advance the model at the edge
   task automatic run_cycle(input string tag);
      @(negedge clk);
      check_model(tag);
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic drive(input bit vl, input bit is, input logic [31:0] sv,
                        input logic [31:0] ar, input bit rd);
      valid = vl; is_syscall = is; v0 = sv; a0 = ar; out_ready = rd;
   endtask

   // Asynchronous reset with outputs checked before any clock edge
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk($sformatf("%s rst stall", tag), {31'd0, stall}, 32'd0);
      chk($sformatf("%s rst out_valid", tag), {31'd0, out_valid}, 32'd0);
      chk($sformatf("%s rst halt", tag), {31'd0, halt}, 32'd0);
      chk($sformatf("%s rst count", tag), {16'd0, syscall_count}, 32'd0);
      chk($sformatf("%s rst out_data", tag), out_data, 32'd0);
      chk($sformatf("%s rst out_type", tag), {30'd0, out_type}, 32'd0);
      m_reset();
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input bit vl, input bit is, input logic [31:0] sv,
                               input logic [31:0] ar, input bit rd, input bit es,
                               input bit ev, input logic [31:0] ed,
                               input logic [1:0] et, input int unsigned ec);
      vec_t r;
      r.vld = vl; r.iss = is; r.v0 = sv; r.a0 = ar; r.rdy = rd;
      r.e_stall = es; r.e_ov = ev; r.e_data = ed; r.e_type = et; r.e_cnt = ec;
      tbl.push_back(r);
   endfunction

   initial begin
      logic [31:0] rv;
      int          pick;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      rst_n = 1'b0;
      do_reset("init");

      // Print int, ready tied high, syscall held through DONE
      add(1, 1, 32'd1, 32'hFFFFFFF6, 1, 1, 0, 32'd0, 2'b00, 0);
      add(1, 1, 32'd1, 32'hFFFFFFF6, 1, 1, 1, 32'hFFFFFFF6, 2'b01, 0);
      add(1, 1, 32'd1, 32'hFFFFFFF6, 1, 0, 0, 32'd0, 2'b00, 0);
      add(0, 1, 32'd1, 32'hFFFFFFF6, 1, 0, 0, 32'd0, 2'b00, 1);
      // Unknown service, then IsSyscall without Valid
      add(1, 1, 32'd5, 32'd7, 1, 0, 0, 32'd0, 2'b00, 1);
      add(0, 1, 32'd1, 32'd7, 1, 0, 0, 32'd0, 2'b00, 2);
      add(0, 0, 32'd0, 32'd0, 1, 0, 0, 32'd0, 2'b00, 2);
      // Print char with ready low for five cycles
      add(1, 1, 32'd11, 32'h12345641, 0, 1, 0, 32'd0, 2'b00, 2);
      for (int i = 0; i < 5; i++)
         add(1, 1, 32'd11, 32'h12345641, 0, 1, 1, 32'h00000041, 2'b10, 2);
      add(1, 1, 32'd11, 32'h12345641, 1, 1, 1, 32'h00000041, 2'b10, 2);
      add(1, 1, 32'd11, 32'h12345641, 1, 0, 0, 32'd0, 2'b00, 2);
      add(0, 0, 32'd11, 32'h12345641, 1, 0, 0, 32'd0, 2'b00, 3);

      foreach (tbl[i]) begin
         drive(tbl[i].vld, tbl[i].iss, tbl[i].v0, tbl[i].a0, tbl[i].rdy);
         @(negedge clk);
         chk($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
         chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
         chk($sformatf("vec%0d halt", i), {31'd0, halt}, 32'd0);
         chk($sformatf("vec%0d count", i), {16'd0, syscall_count}, tbl[i].e_cnt);
         if (tbl[i].e_ov) begin
            chk($sformatf("vec%0d out_data", i), out_data, tbl[i].e_data);
            chk($sformatf("vec%0d out_type", i), {30'd0, out_type}, {30'd0, tbl[i].e_type});
         end
         @(posedge clk);
         #1;
      end

      // Exit: halt persists for 100 cycles under further triggers
      do_reset("pre_exit");
      drive(1'b1, 1'b1, 32'd5, 32'd0, 1'b0);
      run_cycle("exit_unk");
      drive(1'b1, 1'b1, 32'd10, 32'd0, 1'b0);
      run_cycle("exit_trig");
      for (int i = 0; i < 100; i++) begin
         drive(1'($urandom), 1'b1, (i % 2 == 0) ? 32'd1 : 32'd10, $urandom, 1'($urandom));
         run_cycle("halted");
      end
      chk("halt_count", {16'd0, syscall_count}, 32'd2);
      do_reset("exit_rst");

      // Reset while a print is held in ISSUE
      drive(1'b1, 1'b1, 32'd3, 32'd0, 1'b0);
      run_cycle("mid_unk");
      drive(1'b1, 1'b1, 32'd1, 32'hCAFEF00D, 1'b0);
      run_cycle("mid_trig");
      run_cycle("mid_issue");
      do_reset("mid_issue");
      run_cycle("after_mid");

      // Sixteen prints wrap the 4-bit counter
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 1'b1, (k % 2 == 0) ? 32'd1 : 32'd11, $urandom, 1'b1);
         for (int c = 0; c < 3; c++) run_cycle($sformatf("wrap%0d", k));
      end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      run_cycle("wrap_end");
      chk("wrap count16", {16'd0, syscall_count}, 32'd16);
      chk("wrap count4", {28'd0, syscall_count4}, 32'd0);

      // Randomized traffic against the model
      do_reset("rnd_start");
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset("rnd");
         end else begin
            pick = $urandom_range(0, 99);
            if (pick < 35)      rv = 32'd1;
            else if (pick < 70) rv = 32'd11;
            else if (pick < 71) rv = 32'd10;
            else if (pick < 85) rv = 32'd5;
            else                rv = $urandom;
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rv,
                  $urandom, ($urandom_range(0, 9) < 6));
            run_cycle("rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
